// File: rtl/ovl_handshake_arbiter.sv
// ovl_handshake_arbiter: round-robin arbiter sharing one req/ack handshake target with gap, timeout and protocol-error tracking
module ovl_handshake_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_ACK_CYCLE  = 16,
    parameter int DEASSERT_COUNT = 1,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_in,
    output logic [NUM_REQ-1:0]         ack_out,
    output logic                       req_out,
    input  logic                       ack_in,
    output logic                       grant_vld,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       timeout,
    output logic                       proto_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [CNT_WIDTH-1:0] ACK_LAST = CNT_WIDTH'(MAX_ACK_CYCLE - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(DEASSERT_COUNT > 0 ? DEASSERT_COUNT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [IW-1:0]        last_ptr, lp_nxt, gi_nxt, pick, idx;
    logic                 gv_nxt, to_nxt, pe_nxt;

    // First pending requester after last_ptr; iterating from the far end lets the nearest one win
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_ptr) + k) % NUM_REQ);
            if (req_in[idx]) pick = idx;
        end
    end

    // Next-state logic; ack_in beats a dropped request, which beats the timeout
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gv_nxt    = grant_vld;
        gi_nxt    = grant_idx;
        lp_nxt    = last_ptr;
        to_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        case (state)
            IDLE: if (|req_in) begin
                state_nxt = REQ;
                gv_nxt    = 1'b1;
                gi_nxt    = pick;
                cnt_nxt   = '0;
            end
            REQ: begin
                cnt_nxt = cnt + 1'b1;
                if (ack_in) state_nxt = ACK;
                else if (!req_in[grant_idx]) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    pe_nxt    = 1'b1;
                end else if (MAX_ACK_CYCLE != 0 && cnt == ACK_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    to_nxt    = 1'b1;
                end
            end
            ACK: if (!req_in[grant_idx] && !ack_in) begin
                state_nxt = GAP;
                cnt_nxt   = '0;
            end
            GAP: if (cnt == GAP_LAST && !ack_in) begin
                state_nxt = IDLE;
                gv_nxt    = 1'b0;
                lp_nxt    = grant_idx;
            end else if (cnt != GAP_LAST) cnt_nxt = cnt + 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Acknowledge only reaches the owner while its transaction is live; stray acks are dropped
    always_comb begin
        ack_out = '0;
        if (ack_in && grant_vld && (state == REQ || state == ACK)) ack_out[grant_idx] = 1'b1;
    end

    assign req_out = (state == REQ) || (state == ACK && req_in[grant_idx]);

    // State registers; reset makes requester 0 the first in line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            last_ptr  <= IW'(NUM_REQ - 1);
            timeout   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            grant_vld <= gv_nxt;
            grant_idx <= gi_nxt;
            last_ptr  <= lp_nxt;
            timeout   <= to_nxt;
            proto_err <= pe_nxt;
        end
    end
endmodule
